ehl_gpio_bus_arb: RTL and testbench
===================================

// Module: ehl_gpio_bus_arb
// PURPOSE
//   Round-robin arbiter sharing one generic GPIO register port (wr/rd/adr/wdata/rdata/ready) between NREQ requesters,
//   e.g. the APB bridge and an autonomous pin-sequencer. Serialises accesses, supports a bus lock for read-modify-write
//   sequences, and aborts accesses whose target never raises ready (watchdog). Sits between masters and ehl_gpio_top.
// PARAMETERS
//   NREQ       2    number of requesters, 2..4
//   WIDTH      32   data width
//   ADR_WIDTH  6    register address width
//   TIMEOUT    15   max ACCESS cycles waiting for ready before abort; 0 = watchdog disabled (wait forever)
// PORTS
//   clk        in   1                single clock, all logic on rising edge
//   reset      in   1                synchronous, active-high
//   req_wr     in   NREQ             per-requester write request (level, held until ack)
//   req_rd     in   NREQ             per-requester read request (level, held until ack)
//   req_lock   in   NREQ             requester holds bus after its ack while high
//   req_adr    in   NREQ*ADR_WIDTH   packed addresses, requester i at [i*ADR_WIDTH +: ADR_WIDTH]
//   req_wdata  in   NREQ*WIDTH       packed write data, requester i at [i*WIDTH +: WIDTH]
//   req_ack    out  NREQ             one-cycle completion pulse to granted requester
//   req_err    out  NREQ             with req_ack: access aborted by watchdog
//   req_rdata  out  WIDTH            read data, valid in ack cycle (shared by all requesters)
//   wr         out  1                target write strobe
//   rd         out  1                target read strobe
//   adr        out  ADR_WIDTH        target address
//   wdata      out  WIDTH            target write data
//   rdata      in   WIDTH            target read data, sampled when ready=1
//   ready      in   1                target completion
//   busy       out  1                state != IDLE or lock held
// BEHAVIOUR
//   - Reset values: all outputs 0; state IDLE; rr pointer = NREQ-1 (requester 0 wins first); no lock owner; timer 0.
//   - Request i pending = req_wr[i] | req_rd[i]; both high -> write. Requester keeps adr/wdata/request stable until ack.
//   - FSM IDLE -> ACCESS -> RESP -> IDLE:
//     IDLE: if a lock owner exists and req_lock[owner]=1, only owner is eligible; otherwise lock cleared and eligible =
//       all pending. Pick first eligible after rr pointer (wrap NREQ-1 -> 0). Register grant, direction, adr, wdata;
//       pointer := grant; if req_lock[grant]=1 set lock owner = grant. Go ACCESS. Nothing eligible: stay IDLE.
//     ACCESS: wr or rd = 1 for every cycle in this state; adr/wdata from registers, stable. Timer counts from 0.
//       ready=1: capture rdata (reads; writes capture 0), err=0, go RESP. Else if TIMEOUT!=0 and timer==TIMEOUT-1:
//       err=1, rdata=0, go RESP. ready and timeout in same cycle -> ready wins (no error).
//     RESP: req_ack[grant]=1, req_err[grant]=err, req_rdata valid, wr=rd=0. Go IDLE.
//   - Latency: request in IDLE cycle n, ready tied 1 -> wr/rd high in cycle n+1 only, ack in n+2. Min 3 cycles/transfer;
//     back-to-back from the same requester re-enters IDLE, so max throughput one access per 3 cycles.
//   - Requester deasserting request in ACCESS: access still completes and acks (no cancel).
//   - Lock: owner keeps exclusive grant across transfers while req_lock high; lock drops in first IDLE cycle where
//     req_lock[owner]=0, arbitration in that same cycle includes all requesters.
//   - Reset mid-transfer: wr/rd drop on the reset edge, no ack issued, lock cleared; requests still high re-arbitrate
//     after reset from requester 0.
//   - req_ack/req_err/req_rdata outside ack cycle: 0.
//   - Timer width $clog2(TIMEOUT+1); never wraps (leaves ACCESS on terminal count).
// TESTING
//   1 Single read: req_rd[0]=1 adr=6'h08, ready=1, rdata=32'hA5A5_0001 -> rd high 1 cycle, ack[0] 2 cycles after request,
//     req_rdata=32'hA5A5_0001.
//   2 Contention NREQ=2: both request continuously writes -> grants 0,1,0,1; each ack 3 cycles apart, wdata matches owner.
//   3 Lock: req0 lock=1 issues 3 writes while req1 requests -> 3 acks to req0 first; req1 granted in the IDLE cycle
//     after req_lock[0] falls.
//   4 Watchdog TIMEOUT=4, ready=0 -> rd high exactly 4 cycles, ack+err to requester, req_rdata=0; ready on 4th cycle -> no err.
//   5 Reset asserted while in ACCESS with ready=0 -> next cycle wr=rd=0, no ack; after release, pending req re-served.

Source files
------------

// File: rtl/ehl_gpio_bus_arb.sv
// ehl_gpio_bus_arb: round-robin arbiter sharing one GPIO register port
// between NREQ requesters, with bus lock and ready watchdog.
module ehl_gpio_bus_arb #(
    parameter int NREQ      = 2,
    parameter int WIDTH     = 32,
    parameter int ADR_WIDTH = 6,
    parameter int TIMEOUT   = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_wr,
    input  logic [NREQ-1:0]           req_rd,
    input  logic [NREQ-1:0]           req_lock,
    input  logic [NREQ*ADR_WIDTH-1:0] req_adr,
    input  logic [NREQ*WIDTH-1:0]     req_wdata,
    output logic [NREQ-1:0]           req_ack,
    output logic [NREQ-1:0]           req_err,
    output logic [WIDTH-1:0]          req_rdata,
    output logic                      wr,
    output logic                      rd,
    output logic [ADR_WIDTH-1:0]      adr,
    output logic [WIDTH-1:0]          wdata,
    input  logic [WIDTH-1:0]          rdata,
    input  logic                      ready,
    output logic                      busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]        r_gnt;
    logic [IW-1:0]        r_ptr;
    logic                 r_lock_vld;
    logic [IW-1:0]        r_lock_own;
    logic                 r_is_wr;
    logic [ADR_WIDTH-1:0] r_adr;
    logic [WIDTH-1:0]     r_wdata;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_err;
    logic [TW-1:0]        r_timer;

    logic [NREQ-1:0]      w_pend;
    logic [NREQ-1:0]      w_elig;
    logic                 w_lock_keep;
    logic                 w_found;
    logic [IW-1:0]        w_pick;
    logic [IW-1:0]        w_cand;
    logic                 w_tmo;

    // Eligibility: a live lock restricts the grant to its owner.
    always_comb begin
        w_pend      = req_wr | req_rd;
        w_lock_keep = r_lock_vld && req_lock[r_lock_own];
        w_elig      = w_lock_keep ?
                      (w_pend & (NREQ'(1) << r_lock_own)) : w_pend;
    end

    // Round-robin pick: first eligible requester after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_tmo = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));

    // Next-state logic for the IDLE -> ACCESS -> RESP cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_found) w_next = S_ACCESS;
            S_ACCESS: if (ready || w_tmo) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Grant capture, lock ownership, watchdog timer and response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= '0;
            r_ptr      <= IW'(NREQ - 1);
            r_lock_vld <= 1'b0;
            r_lock_own <= '0;
            r_is_wr    <= 1'b0;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_timer    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_lock_keep) r_lock_vld <= 1'b0;
                    if (w_found) begin
                        r_gnt   <= w_pick;
                        r_ptr   <= w_pick;
                        r_is_wr <= req_wr[w_pick];
                        r_adr   <= req_adr[w_pick*ADR_WIDTH +: ADR_WIDTH];
                        r_wdata <= req_wdata[w_pick*WIDTH +: WIDTH];
                        r_timer <= '0;
                        if (req_lock[w_pick]) begin
                            r_lock_vld <= 1'b1;
                            r_lock_own <= w_pick;
                        end
                    end
                end
                S_ACCESS: begin
                    if (ready) begin
                        r_rdata <= r_is_wr ? '0 : rdata;
                        r_err   <= 1'b0;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign wr        = (r_state == S_ACCESS) &  r_is_wr;
    assign rd        = (r_state == S_ACCESS) & ~r_is_wr;
    assign adr       = r_adr;
    assign wdata     = r_wdata;
    assign req_ack   = (r_state == S_RESP) ? (NREQ'(1) << r_gnt) : '0;
    assign req_err   = req_ack & {NREQ{r_err}};
    assign req_rdata = (r_state == S_RESP) ? r_rdata : '0;
    assign busy      = (r_state != S_IDLE) | r_lock_vld;

endmodule

// File: tb/tb_ehl_gpio_bus_arb.sv
// tb_ehl_gpio_bus_arb: directed checks of arbitration order, lock,
// watchdog abort and reset recovery of ehl_gpio_bus_arb.
module tb_ehl_gpio_bus_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_wr;
    logic [1:0]  req_rd;
    logic [1:0]  req_lock;
    logic [11:0] req_adr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ack;
    logic [1:0]  req_err;
    logic [31:0] req_rdata;
    logic        wr;
    logic        rd;
    logic [5:0]  adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    ehl_gpio_bus_arb #(
        .NREQ(2), .WIDTH(32), .ADR_WIDTH(6), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_wr(req_wr), .req_rd(req_rd), .req_lock(req_lock),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
        .wr(wr), .rd(rd), .adr(adr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_wr    = '0;
        req_rd    = '0;
        req_lock  = '0;
        req_adr   = '0;
        req_wdata = '0;
        rdata     = '0;
        ready     = 1'b0;
        tick();
        tick();
        chk("rst_wr",    wr, 0);
        chk("rst_rd",    rd, 0);
        chk("rst_ack",   req_ack, 0);
        chk("rst_err",   req_err, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_adr",   adr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy",  busy, 0);
        reset = 1'b0;

        // single read
        req_rd[0]      = 1'b1;
        req_adr[0+:6]  = 6'h08;
        ready          = 1'b1;
        rdata          = 32'hA5A5_0001;
        tick();
        chk("rd1_rd",   rd, 1);
        chk("rd1_wr",   wr, 0);
        chk("rd1_adr",  adr, 6'h08);
        chk("rd1_ack0", req_ack, 0);
        chk("rd1_busy", busy, 1);
        tick();
        chk("rd1_rdlo",  rd, 0);
        chk("rd1_ack",   req_ack, 2'b01);
        chk("rd1_err",   req_err, 0);
        chk("rd1_rdata", req_rdata, 32'hA5A5_0001);
        req_rd[0] = 1'b0;
        tick();
        chk("rd1_ackd", req_ack, 0);
        chk("rd1_rdz",  req_rdata, 0);
        chk("rd1_idle", busy, 0);

        // contention: both write continuously, grants alternate 0,1,0,1
        do_reset();
        req_wr           = 2'b11;
        req_adr[0+:6]    = 6'h01;
        req_adr[6+:6]    = 6'h02;
        req_wdata[0+:32] = 32'h1111_1111;
        req_wdata[32+:32] = 32'h2222_2222;
        rdata            = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_wr", wr, 1);
            chk("rr_wdata", wdata,
                (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
            chk("rr_adr", adr, (i % 2 == 0) ? 6'h01 : 6'h02);
            tick();
            chk("rr_ack", req_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_wrz", req_rdata, 0);
            if (i == 3) req_wr = 2'b00;
            tick();
            chk("rr_gap", req_ack, 0);
        end

        // lock: requester 0 holds the bus for 3 writes
        do_reset();
        req_wr            = 2'b11;
        req_lock          = 2'b01;
        req_wdata[32+:32] = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            req_wdata[0+:32] = 32'h3000_0000 + 32'(i);
            tick();
            chk("lk_wdata", wdata, 32'h3000_0000 + 32'(i));
            tick();
            chk("lk_ack", req_ack, 2'b01);
            if (i == 2) begin
                req_wr[0]   = 1'b0;
                req_lock[0] = 1'b0;
            end
            tick();
            if (i < 2) chk("lk_busy", busy, 1);
        end
        tick();
        chk("lk_r1_wr", wr, 1);
        chk("lk_r1_wdata", wdata, 32'h2222_2222);
        tick();
        chk("lk_r1_ack", req_ack, 2'b10);
        req_wr = 2'b00;
        tick();
        chk("lk_free", busy, 0);

        // watchdog abort after 4 ACCESS cycles
        ready         = 1'b0;
        rdata         = 32'h0000_DEAD;
        req_rd[0]     = 1'b1;
        req_adr[0+:6] = 6'h03;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wd_rd", rd, 1);
            chk("wd_noack", req_ack, 0);
        end
        tick();
        chk("wd_rdlo",  rd, 0);
        chk("wd_ack",   req_ack, 2'b01);
        chk("wd_err",   req_err, 2'b01);
        chk("wd_rdata", req_rdata, 0);
        tick();
        chk("wd_idle", req_ack, 0);

        // ready on the terminal cycle wins over the watchdog
        rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wd2_rd", rd, 1);
            if (i == 3) ready = 1'b1;
        end
        tick();
        chk("wd2_ack",   req_ack, 2'b01);
        chk("wd2_err",   req_err, 0);
        chk("wd2_rdata", req_rdata, 32'h0BAD_F00D);
        req_rd[0] = 1'b0;
        ready     = 1'b0;
        tick();

        // reset during ACCESS drops the strobe and the lock
        req_wr[1]         = 1'b1;
        req_lock[1]       = 1'b1;
        req_adr[6+:6]     = 6'h2A;
        req_wdata[32+:32] = 32'h2222_5555;
        tick();
        chk("rs_wr", wr, 1);
        reset = 1'b1;
        tick();
        chk("rs_wrlo", wr, 0);
        chk("rs_ack",  req_ack, 0);
        chk("rs_busy", busy, 0);
        reset = 1'b0;
        ready = 1'b1;
        tick();
        chk("rs_re_wr",    wr, 1);
        chk("rs_re_adr",   adr, 6'h2A);
        chk("rs_re_wdata", wdata, 32'h2222_5555);
        tick();
        chk("rs_re_ack", req_ack, 2'b10);
        req_wr   = 2'b00;
        req_lock = 2'b00;
        tick();
        chk("rs_lockheld", busy, 1);
        tick();
        chk("rs_lockdrop", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
